// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and defaults for the I2C register-write slave.
// The register file is built only when I2C_REG_SLAVE_RF_EN is defined.
package i2c_reg_slave_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR     = 3'd1;
    localparam state_t ST_ACK_ADDR = 3'd2;
    localparam state_t ST_BYTE1    = 3'd3;
    localparam state_t ST_ACK1     = 3'd4;
    localparam state_t ST_BYTE2    = 3'd5;
    localparam state_t ST_ACK2     = 3'd6;
    localparam state_t ST_IGNORE   = 3'd7;

    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h1A;
    localparam logic [3:0] DEF_FILT_LEN   = 4'd3;
    localparam int         REG_NUM        = 128;

    // Returns {new_level, new_count}; level flips once len differing samples seen.
    function automatic logic [4:0] filt_step(
        input logic       smp,
        input logic       lvl,
        input logic [3:0] cnt,
        input logic [3:0] len
    );
        logic [3:0] nxt;
        if (smp == lvl) begin
            return {lvl, 4'd0};
        end
        nxt = cnt + 4'd1;
        if (nxt >= len) begin
            return {smp, 4'd0};
        end
        return {lvl, nxt};
    endfunction

endpackage

// File: rtl/i2c_bus_filter.sv
// Synchroniser, glitch filter and START/STOP/SCL-edge detection
// for one SCL/SDA pair. Idle bus level (1) is the reset state.
module i2c_bus_filter
    import i2c_reg_slave_pkg::*;
#(
    parameter logic [3:0] FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_f,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall
);

    logic [1:0] scl_s_q, scl_s_d;
    logic [1:0] sda_s_q, sda_s_d;
    logic       scl_f_q, scl_f_d;
    logic       sda_f_q, sda_f_d;
    logic [3:0] scl_cnt_q, scl_cnt_d;
    logic [3:0] sda_cnt_q, sda_cnt_d;
    logic       scl_p_q, scl_p_d;
    logic       sda_p_q, sda_p_d;

    always_comb begin
        scl_s_d = {scl_s_q[0], scl};
        sda_s_d = {sda_s_q[0], sda};
        {scl_f_d, scl_cnt_d} = filt_step(scl_s_q[1], scl_f_q, scl_cnt_q, FILT_LEN);
        {sda_f_d, sda_cnt_d} = filt_step(sda_s_q[1], sda_f_q, sda_cnt_q, FILT_LEN);
        scl_p_d = scl_f_q;
        sda_p_d = sda_f_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_cnt_q <= 4'd0;
            sda_cnt_q <= 4'd0;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
        end else begin
            scl_s_q   <= scl_s_d;
            sda_s_q   <= sda_s_d;
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
            scl_p_q   <= scl_p_d;
            sda_p_q   <= sda_p_d;
        end
    end

    // SCL must be high both before and after the SDA change to count as START/STOP.
    assign sda_f     = sda_f_q;
    assign scl_rise  = scl_f_q & ~scl_p_q;
    assign scl_fall  = ~scl_f_q & scl_p_q;
    assign start_det = sda_p_q & ~sda_f_q & scl_f_q & scl_p_q;
    assign stop_det  = ~sda_p_q & sda_f_q & scl_f_q & scl_p_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C write-only register slave: one {addr[6:0], data[8:0]} write per transaction.
// Define I2C_REG_SLAVE_RF_EN to build the 128x9 register file behind rd_addr/rd_data.
module i2c_reg_slave
    import i2c_reg_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter logic [3:0] FILT_LEN   = DEF_FILT_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data
);

    logic sda_f, start_det, stop_det, scl_rise, scl_fall;

    i2c_bus_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda_in),
        .sda_f     (sda_f),
        .start_det (start_det),
        .stop_det  (stop_det),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall)
    );

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] byte1_q, byte1_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_en_q, wr_en_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        byte1_d   = byte1_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        sh_d      = {sh_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        case (state_q)
                            ST_ADDR: begin
                                if (sh_q[7:1] == SLAVE_ADDR && !sh_q[0]) begin
                                    state_d = ST_ACK_ADDR;
                                end else begin
                                    state_d  = ST_IGNORE;
                                    sda_oe_d = 1'b0;
                                end
                            end
                            ST_BYTE1: begin
                                state_d = ST_ACK1;
                                byte1_d = sh_q;
                            end
                            default: begin
                                state_d   = ST_ACK2;
                                wr_en_d   = 1'b1;
                                wr_addr_d = byte1_q[7:1];
                                wr_data_d = {byte1_q[0], sh_q};
                            end
                        endcase
                    end
                end
                ST_ACK_ADDR, ST_ACK1, ST_ACK2: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        case (state_q)
                            ST_ACK_ADDR: state_d = ST_BYTE1;
                            ST_ACK1:     state_d = ST_BYTE2;
                            default:     state_d = ST_IGNORE;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            sh_q      <= 8'd0;
            byte1_q   <= 8'd0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 9'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            byte1_q   <= byte1_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

`ifdef I2C_REG_SLAVE_RF_EN
    logic [8:0] rf_q [REG_NUM];

    // Written alongside wr_en_q so reads reflect the write from the pulse onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= 9'd0;
            end
        end else if (wr_en_d) begin
            if (wr_addr_d == 7'd0) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    rf_q[i] <= 9'd0;
                end
            end else begin
                rf_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign rd_data = rf_q[rd_addr];
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 9'd0;
`endif

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: vector table of write transactions
// plus hand sequences for glitches, repeated START, register file and reset.
module tb_i2c_reg_slave;

    localparam int Q = 16;
`ifdef I2C_REG_SLAVE_RF_EN
    localparam bit RF = 1'b1;
`else
    localparam bit RF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic [6:0] rd_addr;
    logic [8:0] rd_data;

    assign sda_in = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    i2c_reg_slave dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int   wr_cycles = 0;
    int   wr_pulses = 0;
    int   coinc_err = 0;
    logic prev_wr   = 1'b0;
    logic prev_oe   = 1'b0;

    // wr_en must be a lone pulse on the very cycle sda_oe rises for ACK2
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cycles = wr_cycles + 1;
            if (!prev_wr) wr_pulses = wr_pulses + 1;
            if (!(sda_oe && !prev_oe)) coinc_err = coinc_err + 1;
        end
        prev_wr = wr_en;
        prev_oe = sda_oe;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // early = sda_oe while SCL is high on the last bit sent
    task automatic send_bits(input logic [7:0] b, input int n, output logic early);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; wait_clk(Q);
            scl   = 1'b1;   wait_clk(Q);
            early = sda_oe; wait_clk(Q);
            scl   = 1'b0;   wait_clk(Q);
        end
    endtask

    task automatic ack_bit(output logic ack, output logic rel);
        sda_m = 1'b1;  wait_clk(Q);
        scl   = 1'b1;  wait_clk(Q);
        ack   = sda_oe; wait_clk(Q);
        scl   = 1'b0;  wait_clk(Q);
        rel   = sda_oe;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack,
                             output logic early, output logic rel);
        send_bits(b, 8, early);
        ack_bit(ack, rel);
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          nb;
        logic [3:0]  ack;
        int          nwr;
        logic [6:0]  addr;
        logic [8:0]  data;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int   c0, p0, e0;
        logic a, ea, ra, early_any, rel_any;
        logic [7:0] b;
        c0 = wr_cycles; p0 = wr_pulses; e0 = coinc_err;
        early_any = 1'b0; rel_any = 1'b0;
        i2c_start();
        for (int k = 0; k < v.nb; k++) begin
            b = v.bytes[31-8*k -: 8];
            send_byte(b, a, ea, ra);
            chk($sformatf("v%0d_ack%0d", idx, k), {31'd0, a}, {31'd0, v.ack[3-k]});
            early_any = early_any | ea;
            rel_any   = rel_any | ra;
            if (k == 0) chk($sformatf("v%0d_busy_mid", idx), {31'd0, busy}, 32'd1);
        end
        i2c_stop();
        wait_clk(20);
        chk($sformatf("v%0d_oe_early", idx), {31'd0, early_any}, 32'd0);
        chk($sformatf("v%0d_oe_release", idx), {31'd0, rel_any}, 32'd0);
        chk($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_wr_pulses", idx), wr_pulses - p0, v.nwr);
        chk($sformatf("v%0d_wr_cycles", idx), wr_cycles - c0, v.nwr);
        chk($sformatf("v%0d_wr_coinc", idx), coinc_err - e0, 32'd0);
        chk($sformatf("v%0d_wr_addr", idx), {25'd0, wr_addr}, {25'd0, v.addr});
        chk($sformatf("v%0d_wr_data", idx), {23'd0, wr_data}, {23'd0, v.data});
    endtask

    initial begin
        logic a, ea, ra;
        int   p0;

        vecs[0] = '{32'h3408_7000, 3, 4'b1110, 1, 7'h04, 9'h070};
        vecs[1] = '{32'h3608_7000, 3, 4'b0000, 0, 7'h04, 9'h070};
        vecs[2] = '{32'h3508_7000, 3, 4'b0000, 0, 7'h04, 9'h070};
        vecs[3] = '{32'h3408_0000, 2, 4'b1100, 0, 7'h04, 9'h070};
        vecs[4] = '{32'h34FF_5500, 3, 4'b1110, 1, 7'h7F, 9'h155};
        vecs[5] = '{32'h3402_1122, 4, 4'b1110, 1, 7'h01, 9'h011};

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = 7'd0;
        wait_clk(5);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {23'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_data", {23'd0, rd_data}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // 2-cycle SDA dip while SCL high is shorter than the filter
        sda_m = 1'b0; wait_clk(2);
        sda_m = 1'b1; wait_clk(20);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        sda_m = 1'b0; wait_clk(20);
        chk("start_busy", {31'd0, busy}, 32'd1);
        sda_m = 1'b1; wait_clk(20);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        scl = 1'b0; wait_clk(Q);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // repeated START inside BYTE2 discards the partial write
        p0 = wr_pulses;
        i2c_start();
        send_byte(8'h34, a, ea, ra);
        send_byte(8'h6A, a, ea, ra);
        send_bits(8'hFF, 3, ea);
        i2c_start();
        send_byte(8'h34, a, ea, ra);
        chk("rs_ack_addr", {31'd0, a}, 32'd1);
        send_byte(8'h6A, a, ea, ra);
        chk("rs_ack1", {31'd0, a}, 32'd1);
        send_byte(8'h2D, a, ea, ra);
        chk("rs_ack2", {31'd0, a}, 32'd1);
        i2c_stop();
        wait_clk(20);
        chk("rs_wr_pulses", wr_pulses - p0, 32'd1);
        chk("rs_wr_addr", {25'd0, wr_addr}, 32'd53);
        chk("rs_wr_data", {23'd0, wr_data}, 32'h02D);

        // register file read-back, then soft reset through address 0
        scl = 1'b0; wait_clk(Q);
        rd_addr = 7'd4;
        i2c_start();
        send_byte(8'h34, a, ea, ra);
        send_byte(8'h08, a, ea, ra);
        send_byte(8'h70, a, ea, ra);
        i2c_stop();
        wait_clk(20);
        chk("rf_r4", {23'd0, rd_data}, RF ? 32'h070 : 32'h0);
        scl = 1'b0; wait_clk(Q);
        i2c_start();
        send_byte(8'h34, a, ea, ra);
        send_byte(8'h00, a, ea, ra);
        send_byte(8'h01, a, ea, ra);
        i2c_stop();
        wait_clk(20);
        chk("rf_clear_addr", {25'd0, wr_addr}, 32'd0);
        chk("rf_clear_data", {23'd0, wr_data}, 32'd1);
        chk("rf_r4_cleared", {23'd0, rd_data}, 32'd0);

        // reset mid-BYTE1 aborts; the rest of the byte stream is ignored
        scl = 1'b0; wait_clk(Q);
        p0 = wr_pulses;
        i2c_start();
        send_byte(8'h34, a, ea, ra);
        chk("rm_ack_addr", {31'd0, a}, 32'd1);
        send_bits(8'h08, 4, ea);
        rst = 1'b1; wait_clk(2);
        chk("rm_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; wait_clk(2);
        send_bits(8'h80, 4, ea);
        ack_bit(a, ra);
        chk("rm_ack1", {31'd0, a}, 32'd0);
        send_byte(8'h70, a, ea, ra);
        chk("rm_ack2", {31'd0, a}, 32'd0);
        i2c_stop();
        wait_clk(20);
        chk("rm_wr_pulses", wr_pulses - p0, 32'd0);
        chk("rm_wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("rm_wr_data", {23'd0, wr_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h1A, 7-bit device address that the block acknowledges.
REQ-002 SHALL have parameter FILT_LEN, default 4'd3, consecutive equal samples needed before a filtered SCL/SDA level changes.
REQ-003 clk  input  1  system clock (nominally 50 MHz); one clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 scl  input  1  I2C clock from the bus master.
REQ-006 sda_in  input  1  I2C data as sampled from the bus.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 wr_en  output  1  one-cycle pulse when a complete register write has been received.
REQ-009 wr_addr  output  7  register address of the last write.
REQ-010 wr_data  output  9  register data of the last write.
REQ-011 busy  output  1  high from START to STOP.
REQ-012 rd_addr  input  7  register-file read address.
REQ-013 rd_data  output  9  combinational register-file read data.

Function
REQ-014 SHALL pass scl/sda_in through 2-FF synchronisers, then through a filter that changes level only after FILT_LEN equal samples.
REQ-015 START = filtered SDA falls while filtered SCL is high; STOP = filtered SDA rises while filtered SCL is high.
REQ-016 SHALL sample SDA data bits, MSB first, on filtered SCL rising edges.
REQ-017 FSM states: IDLE, ADDR, ACK_ADDR, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
REQ-018 IDLE->ADDR on START; after 8 bits in ADDR, go to ACK_ADDR if addr==SLAVE_ADDR and R/W==0, otherwise go to IGNORE (no ACK; reads are not supported).
REQ-019 ACK_ADDR->BYTE1->ACK1->BYTE2->ACK2; BYTE1 = {reg_addr[6:0], data[8]}; BYTE2 = data[7:0].
REQ-020 In every ACK state, sda_oe SHALL assert in the cycle after the filtered SCL falling edge that ends bit 8, and deassert after the next filtered SCL falling edge.
REQ-021 wr_en SHALL pulse for exactly 1 cycle, coincident with sda_oe asserting for ACK2; wr_addr/wr_data update in the same cycle and hold until the next write.
REQ-022 After ACK2, go to IGNORE; further bytes are NACKed (one register per transaction).
REQ-023 STOP in any state -> IDLE; a partial transaction produces no wr_en and leaves wr_addr/wr_data unchanged.
REQ-024 START in any non-IDLE state (repeated start) -> ADDR, discarding partial bytes; sda_oe drops on the next cycle.
REQ-025 If START/STOP and an SCL edge are detected in the same cycle, START/STOP takes priority.
REQ-026 busy SHALL rise the cycle after START and fall the cycle after STOP.

Reset
REQ-027 On rst: FSM=IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, bit counter=0, synchronisers/filters=1 (bus idle), register file=0.
REQ-028 rst asserted mid-transaction SHALL abort with no wr_en; after release, the block SHALL wait for a fresh START.

Configuration
REQ-029 Macro I2C_REG_SLAVE_RF_EN defined: include a 128x9 register file written on wr_en; rd_data=reg[rd_addr]; a write to address 0 (soft reset) SHALL clear all entries to 0 in the same cycle.
REQ-030 Macro not defined: no register file; rd_data tied to 0; rd_addr unused; wr_* outputs unchanged.

Structure
REQ-031 Package i2c_reg_slave_pkg SHALL hold the FSM state typedef, the default SLAVE_ADDR and FILT_LEN, and REG_NUM=128.
REQ-032 Sub-module i2c_bus_filter SHALL contain synchroniser, glitch filter and START/STOP/SCL-edge detection, instantiated once for the SCL/SDA pair.

Verification
REQ-033 Address 0x34 (0x1A, W), bytes 0x08, 0x70 -> three ACKs; wr_en one cycle; wr_addr=4, wr_data=9'h070.
REQ-034 Address 0x36 (0x1B) -> no ACK on any byte; no wr_en; busy still high until STOP.
REQ-035 Address 0x35 (read) -> NACK; no wr_en.
REQ-036 STOP after byte 0x08 -> no wr_en; wr_addr/wr_data hold their previous values.
REQ-037 Repeated START during BYTE2, then a full 0x34/0x6A/0x2D write -> single wr_en with wr_addr=53, wr_data=9'h02D.
REQ-038 With RF_EN: write R4=0x070, then R0=0x001 -> rd_data at rd_addr=4 reads 0x070 before the R0 write and 0 after it; rst pulse mid-BYTE1 -> sda_oe=0 and no wr_en.
